mat_mult_seq: RTL

- Sequential, parametrised successor to the combinational-array matrix multiplier.
- Computes C = A x B for an M x K by K x N signed matrix pair using a single time-multiplexed MAC, one multiply-accumulate per clock.
- Uses a start/busy/done handshake and latches its operands, so upstream may change inputs after start.
- Sits beside the existing dot-product datapath; used where area matters more than latency.

---
 rtl/mat_mult_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential signed matrix multiplier C = A x B using one
// time-multiplexed MAC (one multiply-accumulate per clock), row-major order.
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - asynchronous active-low reset
//   start   - request, sampled only in IDLE; operands captured on accept
//   mat_a   - [M_ROWS][K_INNER] x DATA_W signed operand A
//   mat_b   - [K_INNER][N_COLS] x DATA_W signed operand B
//   mat_out - [M_ROWS][N_COLS] x ACC_W signed result registers
//   busy    - high while computing
//   done    - one-cycle completion pulse
//   ovf     - sticky saturation flag (tied 0 unless saturation is built in)
// Optional feature macro: MAT_MULT_SEQ_SAT_EN (saturating accumulate + ovf).
module mat_mult_seq #(
    parameter int M_ROWS  = 2,
    parameter int K_INNER = 2,
    parameter int N_COLS  = 2,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 2*DATA_W+$clog2(K_INNER)+1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [M_ROWS-1:0][K_INNER-1:0][DATA_W-1:0] mat_a,
    input  logic [K_INNER-1:0][N_COLS-1:0][DATA_W-1:0] mat_b,
    output logic [M_ROWS-1:0][N_COLS-1:0][ACC_W-1:0]   mat_out,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     ovf
);

    localparam int IW = (M_ROWS  > 1) ? $clog2(M_ROWS)  : 1;
    localparam int KW = (K_INNER > 1) ? $clog2(K_INNER) : 1;
    localparam int JW = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic [M_ROWS-1:0][K_INNER-1:0][DATA_W-1:0] r_a;
    logic [K_INNER-1:0][N_COLS-1:0][DATA_W-1:0] r_b;
    logic [M_ROWS-1:0][N_COLS-1:0][ACC_W-1:0]   r_out;
    logic signed [ACC_W-1:0]                    r_acc;
    logic [IW-1:0]                              r_i;
    logic [KW-1:0]                              r_k;
    logic [JW-1:0]                              r_j;

    logic signed [DATA_W-1:0]   w_a;
    logic signed [DATA_W-1:0]   w_b;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_sum;
    logic                       w_i_last;
    logic                       w_j_last;
    logic                       w_k_last;
    logic                       w_last;

    assign w_a    = $signed(r_a[r_i][r_k]);
    assign w_b    = $signed(r_b[r_k][r_j]);
    assign w_prod = w_a * w_b;

    assign w_i_last = (r_i == IW'(M_ROWS-1));
    assign w_j_last = (r_j == JW'(N_COLS-1));
    assign w_k_last = (r_k == KW'(K_INNER-1));
    assign w_last   = w_i_last && w_j_last && w_k_last;

`ifdef MAT_MULT_SEQ_SAT_EN
    // Sum is formed wide enough that neither operand nor the carry is lost,
    // then clamped into the ACC_W signed range.
    localparam int SUM_W = ((ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_wide;
    logic                    w_sat;
    logic                    r_ovf;

    assign w_wide = SUM_W'(w_prod) + SUM_W'(r_acc);

    always_comb begin
        w_sat = 1'b0;
        w_sum = w_wide[ACC_W-1:0];
        if (w_wide > SAT_MAX) begin
            w_sum = SAT_MAX[ACC_W-1:0];
            w_sat = 1'b1;
        end else if (w_wide < SAT_MIN) begin
            w_sum = SAT_MIN[ACC_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_ovf <= 1'b0;
        end else if (r_state == CALC && w_sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_sum = ACC_W'(w_prod) + r_acc;
    assign ovf   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_out <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= mat_a;
                        r_b   <= mat_b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                    end
                end
                CALC: begin
                    if (!w_k_last) begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 1'b1;
                    end else begin
                        r_out[r_i][r_j] <= w_sum;
                        r_acc <= '0;
                        r_k   <= '0;
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= w_i_last ? '0 : r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mat_out = r_out;

endmodule
